// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter and its users.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package wb_arbiter_pkg;

  localparam int unsigned NR_WB_PORTS   = 1;
  localparam int unsigned NR_WB_REQ     = 4;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned PRD_BITS      = 6;

  typedef logic [$clog2(NR_WB_REQ)-1:0] wb_req_idx_t;
  typedef logic [NR_WB_REQ-1:0]         wb_bitvector_t;

  // One functional-unit result as written to the PRF / reported to the ROB.
  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] id;
    logic [PRD_BITS-1:0]      prd;
    logic [XLEN-1:0]          rdval;
  } fu_output_t;

  // Round-robin successor with an explicit wrap, so non-power-of-2 counts work.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Request and writeback handshake bundle between the FUs, the arbiter and the PRF/ROB.
// Latency: n/a (wires only).
// Backpressure: req_ready per FU, wb_ready from the writeback consumer.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = NR_WB_REQ
) ();

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  logic [NR_REQ-1:0]             req_valid;
  fu_output_t [NR_REQ-1:0]       req_data;
  logic [NR_REQ-1:0]             req_ready;
  logic                          wb_valid;
  fu_output_t                    wb_data;
  logic                          wb_ready;
  logic [IDX_W-1:0]              wb_grant;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, wb_ready,
    output req_ready, wb_valid, wb_data, wb_grant
  );

  // FU / consumer side.
  modport master (
    output req_valid, req_data, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_grant
  );

endinterface

// File: rtl/wb_arbiter_rr_arb.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies gnt_o with its own accept condition.
module wb_arbiter_rr_arb #(
  parameter  int unsigned NR_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              any_o
);

  int unsigned pos;

  // Scan ptr, ptr+1, ... wrapping, and keep the first valid request found.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    pos       = 0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NR_REQ) pos = pos - NR_REQ;
      if (!any_o && req_i[IDX_W'(pos)]) begin
        any_o     = 1'b1;
        gnt_idx_o = IDX_W'(pos);
      end
    end
    gnt_o[gnt_idx_o] = any_o;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin share of the single writeback port between NR_REQ FU result streams.
// Latency: 1 cycle from req handshake to wb_valid; 1 result per cycle throughput.
// Backpressure: grants only when the output register is empty or being popped, never during flush.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = NR_WB_REQ,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  wb_arbiter_if.slave      bus,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int unsigned     IDX_W   = $clog2(NR_REQ);
  localparam logic [NR_REQ-1:0] ONE_REQ = NR_REQ'(1);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wb_valid_q, wb_valid_d;
  fu_output_t        wb_data_q, wb_data_d;
  logic [IDX_W-1:0]  wb_grant_q, wb_grant_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic [NR_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_req;
  logic              can_accept;
  logic              conflict;

  wb_arbiter_rr_arb #(.NR_REQ(NR_REQ)) u_rr_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  // Holding rst_ni in here keeps req_ready low for the whole reset window.
  assign can_accept    = rst_ni && !flush_i && (!wb_valid_q || bus.wb_ready);
  assign bus.req_ready = gnt & {NR_REQ{can_accept}};
  // v & (v-1) is non-zero exactly when two or more bits are set.
  assign conflict      = |(bus.req_valid & (bus.req_valid - ONE_REQ));

  // Next state: flush beats transfer beats plain pop; statistics run independently.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    wb_valid_d     = wb_valid_q;
    wb_data_d      = wb_data_q;
    wb_grant_d     = wb_grant_q;
    conflict_cnt_d = conflict_cnt_q;

    if (flush_i) begin
      wb_valid_d = 1'b0;
      rr_ptr_d   = '0;
    end else if (any_req && can_accept) begin
      wb_valid_d = 1'b1;
      wb_data_d  = bus.req_data[gnt_idx];
      wb_grant_d = gnt_idx;
      rr_ptr_d   = IDX_W'(rr_wrap_inc(32'(gnt_idx), NR_REQ));
    end else if (wb_valid_q && bus.wb_ready) begin
      wb_valid_d = 1'b0;
    end

    if (conflict && !(&conflict_cnt_q)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // All arbiter state, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_grant_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_grant_q     <= wb_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_grant    = wb_grant_q;
  assign conflict_cnt_o  = conflict_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios for wb_arbiter with a writeback scoreboard and handshake checks.
// Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.
// Expected writebacks are queued by the stimulus and consumed by a separate monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    wb_req_idx_t idx;
    fu_output_t  data;
  } exp_t;

  exp_t       exp_q[$];
  fu_output_t dat[4];
  logic [3:0] pend;
  fu_output_t pdat[4];

  wb_arbiter_if #(.NR_REQ(4)) bus ();

  wb_arbiter #(.NR_REQ(4), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .bus            (bus),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic fu_output_t mk(input int i, input int id);
    fu_output_t m;
    m.pc    = 32'h8000_0000 + 32'(i * 4);
    m.id    = 4'(id);
    m.prd   = 6'(i + 8);
    m.rdval = 32'hC0DE_0000 + 32'(id * 16 + i);
    return m;
  endfunction

  task automatic apply_data();
    for (int i = 0; i < 4; i++) bus.req_data[i] = dat[i];
  endtask

  task automatic drive(input logic [3:0] v, input logic r, input logic f);
    bus.req_valid = v;
    bus.wb_ready  = r;
    flush         = f;
  endtask

  task automatic push(input int idx, input fu_output_t d);
    exp_t e;
    e.idx  = wb_req_idx_t'(idx);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wb: actual grant=%0d id=0x%0h required none", bus.wb_grant, bus.wb_data.id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_grant", bus.wb_grant, e.idx);
        check("wb_data", bus.wb_data, e.data);
      end
    end
  end

  // Protocol checks: ready is one-hot or zero, pending requests hold valid and data.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          check("hold_valid", bus.req_valid[i], 1'b1);
          check("hold_data", bus.req_data[i], pdat[i]);
        end
      end
    end
    check("ready_onehot0", $onehot0(bus.req_ready), 1'b1);
    pend = (rst_n && !flush) ? (bus.req_valid & ~bus.req_ready) : 4'b0000;
    for (int i = 0; i < 4; i++) pdat[i] = bus.req_data[i];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_bitvector_t s2_pat [8];
    s2_pat = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    pend  = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = mk(i, 0);
    apply_data();
    drive(4'b1111, 1'b1, 1'b0);

    // Reset state, with every FU requesting.
    #2;
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_wb_grant", bus.wb_grant, 2'd0);
    check("rst_wb_data", bus.wb_data, '0);
    check("rst_cnt", cnt, 4'd0);
    check("rst_rr_ptr", dut.rr_ptr_q, 2'd0);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    tick();
    rst_n = 1'b1;
    drive(4'b0000, 1'b1, 1'b0);
    tick();

    // 1: single request from FU1.
    dat[1] = mk(1, 5);
    apply_data();
    drive(4'b0010, 1'b1, 1'b0);
    neg();
    check("s1_req_ready", bus.req_ready, 4'b0010);
    push(1, dat[1]);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    neg();
    check("s1_wb_valid", bus.wb_valid, 1'b1);
    check("s1_wb_grant", bus.wb_grant, 2'd1);
    check("s1_wb_id", bus.wb_data.id, 4'h5);
    check("s1_rr_ptr", dut.rr_ptr_q, 2'd2);
    tick();

    // Idle flush brings the pointer back to 0.
    drive(4'b0000, 1'b1, 1'b1);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    neg();
    check("flush_rr_ptr", dut.rr_ptr_q, 2'd0);
    tick();

    // 2: all four requesting, then draining one by one.
    for (int i = 0; i < 4; i++) dat[i] = mk(i, 10 + i);
    apply_data();
    for (int k = 0; k < 8; k++) begin
      drive(s2_pat[k], 1'b1, 1'b0);
      neg();
      check("s2_req_ready", bus.req_ready, 4'b0001 << (k % 4));
      check("s2_cnt", cnt, 4'(k));
      push(k % 4, dat[k % 4]);
      tick();
    end

    // 3: back-pressure holds the output and blocks grants.
    dat[0] = mk(0, 3);
    apply_data();
    drive(4'b0001, 1'b1, 1'b0);
    neg();
    check("s3_req_ready", bus.req_ready, 4'b0001);
    check("s3_cnt", cnt, 4'd7);
    push(0, dat[0]);
    tick();
    dat[0] = mk(0, 4);
    apply_data();
    drive(4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      neg();
      check("s3_bp_ready", bus.req_ready, 4'b0000);
      check("s3_bp_valid", bus.wb_valid, 1'b1);
      check("s3_bp_id", bus.wb_data.id, 4'h3);
      tick();
    end
    drive(4'b0001, 1'b1, 1'b0);
    neg();
    check("s3_release_ready", bus.req_ready, 4'b0001);
    push(0, dat[0]);
    tick();

    // 4: flush wins over a pop and blocks the FU3 grant for one cycle.
    dat[1] = mk(1, 6);
    apply_data();
    drive(4'b0010, 1'b1, 1'b0);
    neg();
    check("s4_pre_ready", bus.req_ready, 4'b0010);
    tick();
    dat[3] = mk(3, 7);
    apply_data();
    drive(4'b1000, 1'b1, 1'b1);
    neg();
    check("s4_flush_ready", bus.req_ready, 4'b0000);
    tick();
    drive(4'b1000, 1'b1, 1'b0);
    neg();
    check("s4_wb_valid", bus.wb_valid, 1'b0);
    check("s4_rr_ptr", dut.rr_ptr_q, 2'd0);
    check("s4_data_kept", bus.wb_data.id, 4'h6);
    check("s4_grant_kept", bus.wb_grant, 2'd1);
    check("s4_req_ready", bus.req_ready, 4'b1000);
    push(3, dat[3]);
    tick();

    // 5: asynchronous reset between edges while the output is full.
    dat[2] = mk(2, 8);
    apply_data();
    drive(4'b0100, 1'b1, 1'b0);
    neg();
    check("s5_pre_ready", bus.req_ready, 4'b0100);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_valid", bus.wb_valid, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    check("s5_rst_ready", bus.req_ready, 4'b0000);
    neg();
    check("s5_rst_cnt", cnt, 4'd0);
    check("s5_rst_rr_ptr", dut.rr_ptr_q, 2'd0);
    tick();
    dat[0] = mk(0, 1);
    dat[2] = mk(2, 9);
    apply_data();
    rst_n = 1'b1;
    drive(4'b0101, 1'b1, 1'b0);
    neg();
    check("s5_first_grant", bus.req_ready, 4'b0001);
    push(0, dat[0]);
    tick();
    drive(4'b0100, 1'b1, 1'b0);
    neg();
    check("s5_second_grant", bus.req_ready, 4'b0100);
    check("s5_cnt", cnt, 4'd1);
    push(2, dat[2]);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    neg();
    tick();

    // 6: conflict counter saturates at all-ones.
    dat[0] = mk(0, 2);
    dat[1] = mk(1, 3);
    apply_data();
    drive(4'b0011, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      neg();
      check("s6_cnt", cnt, (k + 1 > 15) ? 4'd15 : 4'(k + 1));
      if (k == 0) begin
        check("s6_first_ready", bus.req_ready, 4'b0001);
        push(0, dat[0]);
      end else begin
        check("s6_bp_ready", bus.req_ready, 4'b0000);
      end
      tick();
    end
    drive(4'b0011, 1'b1, 1'b0);
    neg();
    check("s6_cnt_sat", cnt, 4'd15);
    check("s6_drain1_ready", bus.req_ready, 4'b0010);
    push(1, dat[1]);
    tick();
    drive(4'b0001, 1'b1, 1'b0);
    neg();
    check("s6_drain2_ready", bus.req_ready, 4'b0001);
    push(0, dat[0]);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    neg();
    check("s6_cnt_final", cnt, 4'd15);
    tick();
    neg();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
